// File: rtl/vx_tag_flush_ctrl.sv
// Tag-store initialise/flush walker: invalidates every line after reset or on
// request, and otherwise passes core fills through to the tag-store write port.
module vx_tag_flush_ctrl #(
  parameter int LINES_PER_BANK = 64,
  parameter int LINE_SEL_BITS  = $clog2(LINES_PER_BANK)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic                     busy,
  input  logic                     core_valid,
  input  logic                     core_fill,
  input  logic [LINE_SEL_BITS-1:0] core_addr,
  output logic                     core_ready,
  output logic                     tag_wren,
  output logic [LINE_SEL_BITS-1:0] tag_addr,
  output logic                     tag_is_flush
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LINE_SEL_BITS-1:0] LAST_LINE = LINE_SEL_BITS'(LINES_PER_BANK - 1);

  state_t                   state;
  logic [LINE_SEL_BITS-1:0] counter;
  logic                     pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= INIT;
      counter <= '0;
      pending <= 1'b0;
    end else begin
      case (state)
        INIT, FLUSH: begin
          if (flush_req) pending <= 1'b1;
          if (!stall) begin
            // Power-of-two depth: the increment wraps to 0 after the last line.
            counter <= counter + LINE_SEL_BITS'(1);
            if (counter == LAST_LINE) state <= DONE;
          end
        end
        DONE: begin
          // A request arriving in DONE itself merges with any earlier one.
          pending <= 1'b0;
          state   <= (pending || flush_req) ? FLUSH : IDLE;
        end
        IDLE: begin
          if (flush_req) begin
            state   <= FLUSH;
            counter <= '0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  always_comb begin
    flush_done   = 1'b0;
    busy         = 1'b0;
    core_ready   = 1'b0;
    tag_wren     = 1'b0;
    tag_addr     = core_addr;
    tag_is_flush = 1'b0;
    case (state)
      INIT, FLUSH: begin
        busy         = 1'b1;
        // Gated by reset so no write is issued while reset is held.
        tag_wren     = ~stall & reset;
        tag_addr     = counter;
        tag_is_flush = 1'b1;
      end
      IDLE: begin
        core_ready = ~stall;
        tag_wren   = core_valid & core_fill & ~stall;
      end
      DONE: begin
        flush_done = 1'b1;
      end
      default: begin
        flush_done = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_vx_tag_flush_ctrl.sv
// Directed bench for vx_tag_flush_ctrl with the default 64-line tag store.
module tb_vx_tag_flush_ctrl;
  localparam int N = 64;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         stall;
  logic         flush_req;
  logic         flush_done;
  logic         busy;
  logic         core_valid;
  logic         core_fill;
  logic [W-1:0] core_addr;
  logic         core_ready;
  logic         tag_wren;
  logic [W-1:0] tag_addr;
  logic         tag_is_flush;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vx_tag_flush_ctrl #(.LINES_PER_BANK(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush_req   (flush_req),
    .flush_done  (flush_done),
    .busy        (busy),
    .core_valid  (core_valid),
    .core_fill   (core_fill),
    .core_addr   (core_addr),
    .core_ready  (core_ready),
    .tag_wren    (tag_wren),
    .tag_addr    (tag_addr),
    .tag_is_flush(tag_is_flush)
  );

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; flush_req = 1'b0;
    core_valid = 1'b1; core_fill = 1'b1; core_addr = 6'd9;
    #1;
    tests++;
    if ({tag_wren, core_ready, flush_done, busy, tag_is_flush} !== 5'b00011 || tag_addr !== 6'd0) begin
      fails++;
      $display("FAIL reset_async: wren=%b ready=%b done=%b busy=%b flush=%b addr=%0d, want 0 0 0 1 1 addr=0",
               tag_wren, core_ready, flush_done, busy, tag_is_flush, tag_addr);
    end
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({tag_wren, core_ready, flush_done, busy, tag_is_flush} !== 5'b00011 || tag_addr !== 6'd0) begin
      fails++;
      $display("FAIL reset_held: wren=%b ready=%b done=%b busy=%b flush=%b addr=%0d, want 0 0 0 1 1 addr=0",
               tag_wren, core_ready, flush_done, busy, tag_is_flush, tag_addr);
    end
    core_valid = 1'b0; core_fill = 1'b0; core_addr = 6'd0;
  endtask

  task automatic test_init_walk();
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      tests++;
      if (tag_wren !== 1'b1 || tag_is_flush !== 1'b1 || busy !== 1'b1 || core_ready !== 1'b0 ||
          flush_done !== 1'b0 || tag_addr !== W'(i)) begin
        fails++;
        $display("FAIL init_walk cycle %0d: wren=%b flush=%b busy=%b ready=%b done=%b addr=%0d, want 1 1 1 0 0 addr=%0d",
                 i, tag_wren, tag_is_flush, busy, core_ready, flush_done, tag_addr, i);
      end
    end
    @(negedge clk);
    #1;
    tests++;
    if (flush_done !== 1'b1 || tag_wren !== 1'b0 || busy !== 1'b0 || core_ready !== 1'b0) begin
      fails++;
      $display("FAIL init_done: done=%b wren=%b busy=%b ready=%b, want 1 0 0 0",
               flush_done, tag_wren, busy, core_ready);
    end
    @(negedge clk);
    #1;
    tests++;
    if (core_ready !== 1'b1 || flush_done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL init_idle: ready=%b done=%b busy=%b, want 1 0 0", core_ready, flush_done, busy);
    end
  endtask

  task automatic test_core_access();
    @(negedge clk);
    core_valid = 1'b1; core_fill = 1'b1; core_addr = 6'd5;
    #1;
    tests++;
    if (tag_wren !== 1'b1 || tag_addr !== 6'd5 || tag_is_flush !== 1'b0 || core_ready !== 1'b1) begin
      fails++;
      $display("FAIL core_fill: wren=%b addr=%0d flush=%b ready=%b, want 1 5 0 1",
               tag_wren, tag_addr, tag_is_flush, core_ready);
    end
    @(negedge clk);
    core_fill = 1'b0;
    #1;
    tests++;
    if (tag_wren !== 1'b0 || core_ready !== 1'b1) begin
      fails++;
      $display("FAIL core_lookup: wren=%b ready=%b, want 0 1", tag_wren, core_ready);
    end
    @(negedge clk);
    core_fill = 1'b1; stall = 1'b1;
    #1;
    tests++;
    if (tag_wren !== 1'b0 || core_ready !== 1'b0) begin
      fails++;
      $display("FAIL core_stall: wren=%b ready=%b, want 0 0", tag_wren, core_ready);
    end
    @(negedge clk);
    stall = 1'b0; core_valid = 1'b0; core_fill = 1'b0;
  endtask

  task automatic test_stall();
    int e;
    int stalls;
    flush_req = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || core_ready !== 1'b1 || flush_done !== 1'b0) begin
      fails++;
      $display("FAIL stall_req_idle: busy=%b ready=%b done=%b, want 0 1 0", busy, core_ready, flush_done);
    end
    @(negedge clk);
    flush_req = 1'b0; core_valid = 1'b1; core_fill = 1'b1; core_addr = 6'd3;
    e = 0;
    stalls = 0;
    for (int c = 0; c < N + 3; c++) begin
      if (c > 0) @(negedge clk);
      stall = (e == 10 && stalls < 3);
      #1;
      tests++;
      if (stall) begin
        if (tag_wren !== 1'b0 || busy !== 1'b1 || core_ready !== 1'b0) begin
          fails++;
          $display("FAIL stall_hold cycle %0d: wren=%b busy=%b ready=%b, want 0 1 0",
                   c, tag_wren, busy, core_ready);
        end
        stalls++;
      end else begin
        if (tag_wren !== 1'b1 || tag_is_flush !== 1'b1 || busy !== 1'b1 || core_ready !== 1'b0 ||
            flush_done !== 1'b0 || tag_addr !== W'(e)) begin
          fails++;
          $display("FAIL stall_walk cycle %0d: wren=%b flush=%b busy=%b ready=%b done=%b addr=%0d, want 1 1 1 0 0 addr=%0d",
                   c, tag_wren, tag_is_flush, busy, core_ready, flush_done, tag_addr, e);
        end
        e++;
      end
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    tests++;
    if (flush_done !== 1'b1 || tag_wren !== 1'b0 || core_ready !== 1'b0 || tag_addr !== 6'd3) begin
      fails++;
      $display("FAIL stall_done: done=%b wren=%b ready=%b addr=%0d, want 1 0 0 3",
               flush_done, tag_wren, core_ready, tag_addr);
    end
    @(negedge clk);
    core_valid = 1'b0; core_fill = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || core_ready !== 1'b1 || flush_done !== 1'b0) begin
      fails++;
      $display("FAIL stall_idle: busy=%b ready=%b done=%b, want 0 1 0", busy, core_ready, flush_done);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    @(negedge clk);
    flush_req = 1'b1;
    #1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < N; i++) begin
        @(negedge clk);
        flush_req = (pass == 0 && (i == 5 || i == 20));
        #1;
        tests++;
        if (flush_done) pulses++;
        if (tag_wren !== 1'b1 || tag_is_flush !== 1'b1 || busy !== 1'b1 || core_ready !== 1'b0 ||
            flush_done !== 1'b0 || tag_addr !== W'(i)) begin
          fails++;
          $display("FAIL b2b_walk pass %0d cycle %0d: wren=%b flush=%b busy=%b ready=%b done=%b addr=%0d, want 1 1 1 0 0 addr=%0d",
                   pass, i, tag_wren, tag_is_flush, busy, core_ready, flush_done, tag_addr, i);
        end
      end
      @(negedge clk);
      flush_req = 1'b0;
      #1;
      tests++;
      if (flush_done) pulses++;
      if (flush_done !== 1'b1 || tag_wren !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL b2b_done pass %0d: done=%b wren=%b busy=%b, want 1 0 0", pass, flush_done, tag_wren, busy);
      end
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      tests++;
      if (flush_done) pulses++;
      if (busy !== 1'b0 || core_ready !== 1'b1 || flush_done !== 1'b0) begin
        fails++;
        $display("FAIL b2b_idle: busy=%b ready=%b done=%b, want 0 1 0", busy, core_ready, flush_done);
      end
    end
    tests++;
    if (pulses !== 2) begin
      fails++;
      $display("FAIL b2b_pulses: flush_done pulses=%0d, want 2", pulses);
    end
  endtask

  task automatic test_reset_mid_walk();
    @(negedge clk);
    flush_req = 1'b1;
    #1;
    for (int i = 0; i <= 30; i++) begin
      @(negedge clk);
      flush_req = (i == 12);
      #1;
      tests++;
      if (tag_wren !== 1'b1 || busy !== 1'b1 || tag_addr !== W'(i)) begin
        fails++;
        $display("FAIL midrst_walk cycle %0d: wren=%b busy=%b addr=%0d, want 1 1 addr=%0d",
                 i, tag_wren, busy, tag_addr, i);
      end
    end
    #1;
    reset = 1'b0;
    #1;
    tests++;
    if ({tag_wren, core_ready, flush_done, busy, tag_is_flush} !== 5'b00011 || tag_addr !== 6'd0) begin
      fails++;
      $display("FAIL midrst_async: wren=%b ready=%b done=%b busy=%b flush=%b addr=%0d, want 0 0 0 1 1 addr=0",
               tag_wren, core_ready, flush_done, busy, tag_is_flush, tag_addr);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      tests++;
      if (tag_wren !== 1'b1 || tag_is_flush !== 1'b1 || busy !== 1'b1 || flush_done !== 1'b0 ||
          tag_addr !== W'(i)) begin
        fails++;
        $display("FAIL midrst_rewalk cycle %0d: wren=%b flush=%b busy=%b done=%b addr=%0d, want 1 1 1 0 addr=%0d",
                 i, tag_wren, tag_is_flush, busy, flush_done, tag_addr, i);
      end
    end
    @(negedge clk);
    #1;
    tests++;
    if (flush_done !== 1'b1) begin
      fails++;
      $display("FAIL midrst_done: done=%b, want 1", flush_done);
    end
    repeat (2) begin
      @(negedge clk);
      #1;
      tests++;
      if (busy !== 1'b0 || core_ready !== 1'b1) begin
        fails++;
        $display("FAIL midrst_pending_cleared: busy=%b ready=%b, want 0 1", busy, core_ready);
      end
    end
  endtask

  task automatic test_flush_with_fill();
    @(negedge clk);
    flush_req = 1'b1; core_valid = 1'b1; core_fill = 1'b1; core_addr = 6'd7;
    #1;
    tests++;
    if (tag_wren !== 1'b1 || tag_addr !== 6'd7 || tag_is_flush !== 1'b0 || core_ready !== 1'b1) begin
      fails++;
      $display("FAIL fill_with_req: wren=%b addr=%0d flush=%b ready=%b, want 1 7 0 1",
               tag_wren, tag_addr, tag_is_flush, core_ready);
    end
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      flush_req = 1'b0; core_valid = 1'b0; core_fill = 1'b0;
      #1;
      tests++;
      if (tag_wren !== 1'b1 || tag_is_flush !== 1'b1 || busy !== 1'b1 || core_ready !== 1'b0 ||
          tag_addr !== W'(i)) begin
        fails++;
        $display("FAIL fill_walk cycle %0d: wren=%b flush=%b busy=%b ready=%b addr=%0d, want 1 1 1 0 addr=%0d",
                 i, tag_wren, tag_is_flush, busy, core_ready, tag_addr, i);
      end
    end
    @(negedge clk);
    #1;
    tests++;
    if (flush_done !== 1'b1 || tag_wren !== 1'b0) begin
      fails++;
      $display("FAIL fill_done: done=%b wren=%b, want 1 0", flush_done, tag_wren);
    end
    @(negedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || core_ready !== 1'b1) begin
      fails++;
      $display("FAIL fill_idle: busy=%b ready=%b, want 0 1", busy, core_ready);
    end
  endtask

  initial begin
    test_reset();
    test_init_walk();
    test_core_access();
    test_stall();
    test_back_to_back();
    test_reset_mid_walk();
    test_flush_with_fill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
